// File: rtl/data_ram_mmio_pkg.sv
// Shared constants, CTRL register layout and byte-lane merge for the data-memory responder.
package data_ram_mmio_pkg;

    localparam logic [31:0] MMIO_BASE_DEF = 32'h1000_0000;

    localparam logic [7:0] MMIO_GPIO  = 8'h00;
    localparam logic [7:0] MMIO_COUNT = 8'h04;
    localparam logic [7:0] MMIO_CMP   = 8'h08;
    localparam logic [7:0] MMIO_CTRL  = 8'h0C;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_FLAG = 1;
    localparam int CTRL_AR   = 2;
    localparam int CTRL_IE   = 3;

    // Field order matches the CTRL bit indices above (en is bit 0).
    typedef struct packed {
        logic ie;
        logic ar;
        logic flag;
        logic en;
    } timer_ctrl_t;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        res = old_v;
        for (int k = 0; k < 4; k++) begin
            if (sel[k]) res[8*k +: 8] = new_v[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/data_ram_mmio_if.sv
// Data-memory bus between the core's MEM stage and the RAM/MMIO responder.
interface data_ram_mmio_if;
    // ce_i is the request valid; the responder is always ready (zero wait states):
    // a write commits at the edge where ce_i & we_i, read data is valid while ce_i & ~we_i.
    logic        ce_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [3:0]  sel_i;
    logic [31:0] data_i;
    logic [31:0] data_o;

    modport master (output ce_i, we_i, addr_i, sel_i, data_i, input data_o);
    modport slave  (input ce_i, we_i, addr_i, sel_i, data_i, output data_o);
endinterface

// File: rtl/data_ram_mmio_timer.sv
// Compare timer: COUNT/CMP/CTRL registers with match, auto-reload and W1C interrupt flag.
module data_ram_mmio_timer
    import data_ram_mmio_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [7:0]  wr_off,
    input  logic [3:0]  wr_sel,
    input  logic [31:0] wr_data,
    output logic [31:0] count,
    output logic [31:0] cmp,
    output timer_ctrl_t ctrl,
    output logic        irq
);

    logic [31:0] count_next;
    logic [31:0] cmp_next;
    timer_ctrl_t ctrl_next;
    logic        match;
    logic        wr_count;
    logic        wr_cmp;
    logic        wr_ctrl;
    logic        w1c;

    always_comb begin
        match    = ctrl.en && (count == cmp);
        wr_count = wr_en && (wr_off == MMIO_COUNT) && (wr_sel != 4'h0);
        wr_cmp   = wr_en && (wr_off == MMIO_CMP);
        wr_ctrl  = wr_en && (wr_off == MMIO_CTRL) && wr_sel[0];
        w1c      = wr_ctrl && wr_data[CTRL_FLAG];

        // A CPU write to COUNT overrides both increment and reload.
        count_next = count;
        if (wr_count) begin
            count_next = lane_merge(count, wr_data, wr_sel);
        end else if (ctrl.en) begin
            count_next = (match && ctrl.ar) ? 32'h0 : count + 32'd1;
        end

        cmp_next = wr_cmp ? lane_merge(cmp, wr_data, wr_sel) : cmp;

        ctrl_next = ctrl;
        if (wr_ctrl) begin
            ctrl_next.en = wr_data[CTRL_EN];
            ctrl_next.ar = wr_data[CTRL_AR];
            ctrl_next.ie = wr_data[CTRL_IE];
        end
        // Hardware set wins over a same-cycle write-1-to-clear.
        ctrl_next.flag = match | (ctrl.flag & ~w1c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 32'h0;
            cmp   <= 32'h0;
            ctrl  <= '0;
        end else begin
            count <= count_next;
            cmp   <= cmp_next;
            ctrl  <= ctrl_next;
        end
    end

    assign irq = ctrl.flag & ctrl.ie & ~rst;

endmodule

// File: rtl/data_ram_mmio.sv
// Data-memory responder: word RAM with byte-lane writes plus an MMIO page (GPIO, timer).
module data_ram_mmio
    import data_ram_mmio_pkg::*;
#(
    parameter int          RAM_AW    = 10,
    parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEF,
    parameter int          GPIO_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    data_ram_mmio_if.slave    bus,
    output logic [GPIO_W-1:0] gpio_o,
    output logic              irq_o
);

    localparam int DEPTH = 1 << RAM_AW;

    logic [31:0]       mem [0:DEPTH-1];
    logic              is_mmio;
    logic [7:0]        offset;
    logic [RAM_AW-1:0] ram_idx;
    logic              wr;
    logic              rd;
    logic              ram_wr;
    logic [31:0]       gpio_ext;
    logic [31:0]       gpio_merged;
    logic [31:0]       mmio_rd;
    logic [31:0]       t_count;
    logic [31:0]       t_cmp;
    timer_ctrl_t       t_ctrl;
    logic              unused_addr;

    // rst_n is active-high here: accesses during reset are dropped and reads return 0.
    always_comb begin
        is_mmio = (bus.addr_i[31:8] == MMIO_BASE[31:8]);
        offset  = {bus.addr_i[7:2], 2'b00};
        ram_idx = bus.addr_i[RAM_AW+1:2];
        wr      = bus.ce_i & bus.we_i & ~rst_n;
        rd      = bus.ce_i & ~bus.we_i & ~rst_n;
        ram_wr  = wr & ~is_mmio;
    end

    assign unused_addr = ^bus.addr_i[1:0];

    always_ff @(posedge clk) begin
        if (ram_wr) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.sel_i[k]) mem[ram_idx][8*k +: 8] <= bus.data_i[8*k +: 8];
            end
        end
    end

    always_comb begin
        gpio_ext               = 32'h0;
        gpio_ext[GPIO_W-1:0]   = gpio_o;
        gpio_merged            = lane_merge(gpio_ext, bus.data_i, bus.sel_i);
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            gpio_o <= '0;
        end else if (wr && is_mmio && offset == MMIO_GPIO) begin
            gpio_o <= gpio_merged[GPIO_W-1:0];
        end
    end

    data_ram_mmio_timer u_timer (
        .clk     (clk),
        .rst     (rst_n),
        .wr_en   (wr & is_mmio),
        .wr_off  (offset),
        .wr_sel  (bus.sel_i),
        .wr_data (bus.data_i),
        .count   (t_count),
        .cmp     (t_cmp),
        .ctrl    (t_ctrl),
        .irq     (irq_o)
    );

    always_comb begin
        mmio_rd = 32'h0;
        case (offset)
            MMIO_GPIO:  mmio_rd = gpio_ext;
            MMIO_COUNT: mmio_rd = t_count;
            MMIO_CMP:   mmio_rd = t_cmp;
            MMIO_CTRL:  mmio_rd = {28'h0, t_ctrl};
            default:    mmio_rd = 32'h0;
        endcase
        bus.data_o = 32'h0;
        if (rd) bus.data_o = is_mmio ? mmio_rd : mem[ram_idx];
    end

endmodule

// File: tb/tb_data_ram_mmio.sv
// Self-checking bench for data_ram_mmio: directed scenarios plus a randomized mix against a reference model.
module tb_data_ram_mmio;
    import data_ram_mmio_pkg::*;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [23:0] PAGE = 24'h10_0000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] gpio;
    logic       irq;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [31:0] exp_q [$];

    data_ram_mmio_if bus ();

    data_ram_mmio #(.RAM_AW(10), .MMIO_BASE(BASE), .GPIO_W(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .gpio_o (gpio),
        .irq_o  (irq)
    );

    always #5 clk = ~clk;

    // Reference model: architectural state, updated once per rising edge from the bus inputs.
    logic [31:0] m_ram [int];
    logic [7:0]  m_gpio;
    logic [31:0] m_count, m_cmp;
    logic        m_en, m_flag, m_ar, m_ie;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (o & ~mask) | (n & mask);
    endfunction

    function automatic logic [31:0] mmio_expect(input logic [7:0] off);
        case (off)
            8'h00:   return {24'h0, m_gpio};
            8'h04:   return m_count;
            8'h08:   return m_cmp;
            8'h0C:   return {28'h0, m_ie, m_ar, m_flag, m_en};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_step();
        logic wr, hit, match, to_ctrl;
        logic [7:0]  off;
        logic [31:0] c_next, g, old;
        int idx;
        wr  = (bus.ce_i === 1'b1) && (bus.we_i === 1'b1) && (rst_n === 1'b0);
        hit = (bus.addr_i[31:8] == PAGE);
        off = {bus.addr_i[7:2], 2'b00};
        if (rst_n) begin
            m_gpio = 8'h0; m_count = 0; m_cmp = 0;
            m_en = 0; m_flag = 0; m_ar = 0; m_ie = 0;
        end else begin
            match = m_en && (m_count == m_cmp);
            if (wr && hit && off == 8'h04 && bus.sel_i != 4'h0) c_next = merge(m_count, bus.data_i, bus.sel_i);
            else if (!m_en)         c_next = m_count;
            else if (match && m_ar) c_next = 0;
            else                    c_next = m_count + 1;
            to_ctrl = wr && hit && off == 8'h0C && bus.sel_i[0];
            m_flag = match || (m_flag && !(to_ctrl && bus.data_i[1]));
            if (to_ctrl) begin
                m_en = bus.data_i[0]; m_ar = bus.data_i[2]; m_ie = bus.data_i[3];
            end
            if (wr && hit && off == 8'h08) m_cmp = merge(m_cmp, bus.data_i, bus.sel_i);
            if (wr && hit && off == 8'h00) begin
                g = merge({24'h0, m_gpio}, bus.data_i, bus.sel_i);
                m_gpio = g[7:0];
            end
            if (wr && !hit) begin
                idx = int'(bus.addr_i[11:2]);
                old = m_ram.exists(idx) ? m_ram[idx] : 32'h0;
                m_ram[idx] = merge(old, bus.data_i, bus.sel_i);
            end
            m_count = c_next;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Driver tasks
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        bus.ce_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = a; bus.data_i = d; bus.sel_i = s;
        @(posedge clk);
        #1;
        bus.ce_i = 1'b0; bus.we_i = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.ce_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = a;
        #1;
        d = bus.data_o;
        @(posedge clk);
        #1;
        bus.ce_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst_n = 1'b1;
        idle(3);
        n_cmp++; if (gpio !== 8'h0) begin n_bad++; $display("FAIL reset_gpio: got %h want 00", gpio); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b want 0", irq); end
        bus_read(32'h40, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_read_ram: got %h want 0", d); end
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus_read(BASE | (i * 4), d);
            n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_mmio_%0d: got %h want 0", i, d); end
        end
    endtask

    task automatic test_full_word();
        logic [31:0] d;
        bus_write(32'h40, 32'hDEADBEEF, 4'hF);
        bus_read(32'h40, d);
        n_cmp++; if (d !== 32'hDEADBEEF) begin n_bad++; $display("FAIL full_word: got %h want deadbeef", d); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] d;
        bus_write(32'h40, 32'h0000_00AA, 4'h1);
        bus_read(32'h40, d);
        n_cmp++; if (d !== 32'hDEADBEAA) begin n_bad++; $display("FAIL byte_lane: got %h want deadbeaa", d); end
        bus_write(32'h40, 32'h1111_1111, 4'h0);
        bus_read(32'h40, d);
        n_cmp++; if (d !== 32'hDEADBEAA) begin n_bad++; $display("FAIL sel_zero: got %h want deadbeaa", d); end
    endtask

    task automatic test_reset_write();
        logic [31:0] d;
        bus_write(BASE, 32'h5A, 4'hF);
        @(negedge clk);
        rst_n = 1'b1;
        bus_write(32'h40, 32'h1234, 4'hF);
        bus_write(BASE, 32'hFF, 4'hF);
        @(negedge clk);
        rst_n = 1'b0;
        bus_read(32'h40, d);
        n_cmp++; if (d !== 32'hDEADBEAA) begin n_bad++; $display("FAIL write_in_reset: got %h want deadbeaa", d); end
        n_cmp++; if (gpio !== 8'h0) begin n_bad++; $display("FAIL gpio_after_reset: got %h want 00", gpio); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_after_reset: got %b want 0", irq); end
    endtask

    task automatic test_decode();
        logic [31:0] d;
        @(negedge clk);
        bus.ce_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = BASE; bus.data_i = 32'hC3; bus.sel_i = 4'hF;
        #1;
        n_cmp++; if (bus.data_o !== 32'h0) begin n_bad++; $display("FAIL read_while_write: got %h want 0", bus.data_o); end
        @(posedge clk);
        #1;
        bus.ce_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = 32'h40;
        #1;
        n_cmp++; if (bus.data_o !== 32'h0) begin n_bad++; $display("FAIL read_ce_low: got %h want 0", bus.data_o); end
        n_cmp++; if (gpio !== 8'hC3) begin n_bad++; $display("FAIL gpio_write: got %h want c3", gpio); end
        bus_write(32'h0800_1040, 32'h5A5A_0001, 4'hF);
        bus_read(32'h40, d);
        n_cmp++; if (d !== 32'h5A5A_0001) begin n_bad++; $display("FAIL ram_alias: got %h want 5a5a0001", d); end
        bus_write(BASE | 32'h10, 32'hFFFF_FFFF, 4'hF);
        bus_read(BASE | 32'h10, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL unmapped_read: got %h want 0", d); end
        bus_write(BASE | 32'h01, 32'h0000_FF3C, 4'h1);
        bus_read(BASE | 32'h02, d);
        n_cmp++; if (d !== 32'h3C) begin n_bad++; $display("FAIL gpio_low_bits: got %h want 3c", d); end
    endtask

    task automatic test_timer_reload();
        logic [31:0] d;
        logic [31:0] seq [8];
        seq = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd0, 32'd1};
        bus_write(BASE | 32'h08, 32'd5, 4'hF);
        bus_write(BASE | 32'h0C, 32'hD, 4'hF);
        for (int i = 0; i < 8; i++) begin
            bus_read(BASE | 32'h04, d);
            n_cmp++; if (d !== seq[i]) begin n_bad++; $display("FAIL reload_count_%0d: got %0d want %0d", i, d, seq[i]); end
            n_cmp++; if (irq !== (i >= 5)) begin n_bad++; $display("FAIL reload_irq_%0d: got %b want %b", i, irq, (i >= 5)); end
        end
        bus_write(BASE | 32'h0C, 32'hF, 4'hF);
        bus_read(BASE | 32'h0C, d);
        n_cmp++; if (d !== 32'hD) begin n_bad++; $display("FAIL w1c_clear: got %h want d", d); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL w1c_irq: got %b want 0", irq); end
        bus_write(BASE | 32'h0C, 32'h2, 4'hF);
    endtask

    task automatic test_timer_wrap();
        logic [31:0] d;
        logic [31:0] seq [6];
        seq = '{32'hFFFF_FFFF, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4};
        bus_write(BASE | 32'h04, 32'hFFFF_FFFF, 4'hF);
        bus_write(BASE | 32'h08, 32'd3, 4'hF);
        bus_write(BASE | 32'h0C, 32'h1, 4'hF);
        for (int i = 0; i < 6; i++) begin
            bus_read(BASE | 32'h04, d);
            n_cmp++; if (d !== seq[i]) begin n_bad++; $display("FAIL wrap_count_%0d: got %h want %h", i, d, seq[i]); end
            n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL wrap_irq_%0d: got %b want 0", i, irq); end
        end
        bus_read(BASE | 32'h0C, d);
        n_cmp++; if (d !== 32'h3) begin n_bad++; $display("FAIL wrap_flag: got %h want 3", d); end
        bus_write(BASE | 32'h0C, 32'h2, 4'hF);
        bus_read(BASE | 32'h0C, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL wrap_clear: got %h want 0", d); end
    endtask

    task automatic test_simultaneous();
        logic [31:0] d;
        bus_write(BASE | 32'h04, 32'd0, 4'hF);
        bus_write(BASE | 32'h08, 32'd4, 4'hF);
        bus_write(BASE | 32'h0C, 32'h9, 4'hF);
        idle(4);
        bus_write(BASE | 32'h04, 32'd100, 4'hF);
        bus_read(BASE | 32'h04, d);
        n_cmp++; if (d !== 32'd100) begin n_bad++; $display("FAIL count_write_wins: got %0d want 100", d); end
        bus_read(BASE | 32'h0C, d);
        n_cmp++; if (d !== 32'hB) begin n_bad++; $display("FAIL match_flag: got %h want b", d); end
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL match_irq: got %b want 1", irq); end
        bus_write(BASE | 32'h0C, 32'h2, 4'hF);
        bus_write(BASE | 32'h04, 32'd0, 4'hF);
        bus_write(BASE | 32'h08, 32'd2, 4'hF);
        bus_write(BASE | 32'h0C, 32'h9, 4'hF);
        idle(2);
        bus_write(BASE | 32'h0C, 32'hB, 4'hF);
        bus_read(BASE | 32'h0C, d);
        n_cmp++; if (d !== 32'hB) begin n_bad++; $display("FAIL set_beats_w1c: got %h want b", d); end
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL set_beats_w1c_irq: got %b want 1", irq); end
        bus_write(BASE | 32'h0C, 32'h2, 4'hF);
    endtask

    function automatic logic [31:0] ram_addr(input int idx);
        logic [31:0] a;
        a = $urandom;
        a[11:2] = idx[9:0];
        if (a[31:8] == PAGE) a[31] = ~a[31];
        return a;
    endfunction

    task automatic test_random_mix();
        logic [31:0] d, e;
        logic [7:0]  offs [6];
        int          slots [16];
        int          op, k;
        offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'hFC};
        for (int i = 0; i < 16; i++) begin
            slots[i] = 100 + i * 37;
            bus_write(ram_addr(slots[i]), $urandom, 4'hF);
        end
        for (int i = 0; i < 120; i++) begin
            op = $urandom_range(0, 6);
            k  = $urandom_range(0, 15);
            case (op)
                0: bus_write(ram_addr(slots[k]), $urandom, 4'($urandom_range(0, 15)));
                1: begin
                    exp_q.push_back(m_ram[slots[k]]);
                    bus_read(ram_addr(slots[k]), d);
                    e = exp_q.pop_front();
                    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL rand_ram_%0d: got %h want %h", i, d, e); end
                end
                2: bus_write(BASE, $urandom, 4'($urandom_range(0, 15)));
                3: bus_write(BASE | 32'h08, 32'($urandom_range(0, 20)), 4'($urandom_range(0, 15)));
                4: bus_write(BASE | 32'h0C, 32'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
                5: bus_write(BASE | 32'h04, 32'($urandom_range(0, 20)), 4'($urandom_range(0, 15)));
                default: begin
                    k = $urandom_range(0, 5);
                    @(negedge clk);
                    e = mmio_expect(offs[k]);
                    bus.ce_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = BASE | {24'h0, offs[k]};
                    #1;
                    d = bus.data_o;
                    @(posedge clk);
                    #1;
                    bus.ce_i = 1'b0;
                    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL rand_mmio_%0d off %h: got %h want %h", i, offs[k], d, e); end
                end
            endcase
            n_cmp++; if (gpio !== m_gpio) begin n_bad++; $display("FAIL rand_gpio_%0d: got %h want %h", i, gpio, m_gpio); end
            n_cmp++; if (irq !== (m_flag & m_ie)) begin n_bad++; $display("FAIL rand_irq_%0d: got %b want %b", i, irq, m_flag & m_ie); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ce_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = 32'h0; bus.data_i = 32'h0; bus.sel_i = 4'h0;
        test_reset();
        test_full_word();
        test_byte_lanes();
        test_reset_write();
        test_decode();
        test_timer_reload();
        test_timer_wrap();
        test_simultaneous();
        test_random_mix();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
